// File: rtl/axis_rx_frame_writer_if.sv
// RX AXI-Stream bundle (data, byte keep, last, bad-frame user bit) between
// the CDC/width-adapter stage and the frame writer.
interface axis_rx_frame_writer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_rx_frame_writer.sv
// Writes RX frames into two ping-pong packet-buffer slots, publishes per-slot
// length/ready to the CPU, and drops bad, oversize and no-room frames.
module axis_rx_frame_writer #(
  parameter  int DATA_WIDTH     = 64,
  parameter  int KEEP_WIDTH     = 8,
  parameter  int BUF_ADDR_WIDTH = 8,
  localparam int LEN_WIDTH      = BUF_ADDR_WIDTH + $clog2(KEEP_WIDTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axis_rx_frame_writer_if.slave     s_axis,
  output logic                      buf_w_v_o,
  output logic                      buf_w_slot_o,
  output logic [BUF_ADDR_WIDTH-1:0] buf_w_addr_o,
  output logic [DATA_WIDTH-1:0]     buf_w_data_o,
  output logic [KEEP_WIDTH-1:0]     buf_w_mask_o,
  output logic [1:0]                rx_ready_o,
  output logic [2*LEN_WIDTH-1:0]    rx_len_o,
  input  logic [1:0]                rx_clear_i,
  output logic [15:0]               drop_count_o
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t                         r_state;
  logic                           r_tready;
  logic                           r_wr_slot;
  logic [BUF_ADDR_WIDTH:0]        r_word_cnt;
  logic [LEN_WIDTH-1:0]           r_byte_cnt;
  logic [1:0]                     r_rx_ready;
  logic [1:0][LEN_WIDTH-1:0]      r_rx_len;
  logic [15:0]                    r_drop_cnt;
  logic                           r_w_v;
  logic                           r_w_slot;
  logic [BUF_ADDR_WIDTH-1:0]      r_w_addr;
  logic [DATA_WIDTH-1:0]          r_w_data;
  logic [KEEP_WIDTH-1:0]          r_w_mask;

  logic                           w_acc;
  logic                           w_room;
  logic                           w_full;
  logic                           w_wr;
  logic                           w_commit;
  logic                           w_drop;
  logic [LEN_WIDTH-1:0]           w_pop;
  logic [LEN_WIDTH-1:0]           w_total;
  logic [BUF_ADDR_WIDTH-1:0]      w_addr;
  logic [1:0]                     w_set;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      w_pop = w_pop + LEN_WIDTH'(s_axis.tkeep[i]);
  end

  assign w_acc   = s_axis.tvalid & r_tready;
  assign w_room  = ~r_rx_ready[r_wr_slot];
  assign w_full  = r_word_cnt[BUF_ADDR_WIDTH];
  assign w_total = ((r_state == IDLE) ? '0 : r_byte_cnt) + w_pop;
  assign w_addr  = (r_state == IDLE) ? '0 : r_word_cnt[BUF_ADDR_WIDTH-1:0];

  // A beat is written when it starts a frame into a free slot, or continues
  // a frame that still fits; a full slot turns the frame into a drop.
  assign w_wr = w_acc & (((r_state == IDLE) & w_room) |
                         ((r_state == RECV) & ~w_full));
  assign w_commit = w_wr & s_axis.tlast & ~s_axis.tuser & (w_total != '0);
  // Every accepted end-of-frame that does not commit counts as one drop.
  assign w_drop   = w_acc & s_axis.tlast & ~w_commit;
  assign w_set    = {w_commit & r_wr_slot, w_commit & ~r_wr_slot};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tready   <= 1'b0;
      r_wr_slot  <= 1'b0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_rx_ready <= '0;
      r_rx_len   <= '0;
      r_drop_cnt <= '0;
      r_w_v      <= 1'b0;
      r_w_slot   <= 1'b0;
      r_w_addr   <= '0;
      r_w_data   <= '0;
      r_w_mask   <= '0;
    end else begin
      r_tready <= 1'b1;
      r_w_v    <= w_wr;
      if (w_wr) begin
        r_w_slot <= r_wr_slot;
        r_w_addr <= w_addr;
        r_w_data <= s_axis.tdata;
        r_w_mask <= s_axis.tkeep;
      end

      // Set wins over a same-cycle clear of the same slot.
      r_rx_ready <= (r_rx_ready & ~rx_clear_i) | w_set;
      if (w_commit) begin
        r_rx_len[r_wr_slot] <= w_total;
        r_wr_slot           <= ~r_wr_slot;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;

      if (w_acc) begin
        unique case (r_state)
          IDLE: begin
            if (s_axis.tlast) begin
              r_word_cnt <= '0;
              r_byte_cnt <= '0;
            end else if (w_room) begin
              r_state    <= RECV;
              r_word_cnt <= (BUF_ADDR_WIDTH+1)'(1);
              r_byte_cnt <= w_pop;
            end else begin
              r_state <= DROP;
            end
          end
          RECV: begin
            if (s_axis.tlast) begin
              r_state    <= IDLE;
              r_word_cnt <= '0;
              r_byte_cnt <= '0;
            end else if (w_full) begin
              r_state <= DROP;
            end else begin
              r_word_cnt <= r_word_cnt + (BUF_ADDR_WIDTH+1)'(1);
              r_byte_cnt <= w_total;
            end
          end
          DROP: begin
            if (s_axis.tlast) begin
              r_state    <= IDLE;
              r_word_cnt <= '0;
              r_byte_cnt <= '0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign s_axis.tready = r_tready;
  assign buf_w_v_o     = r_w_v;
  assign buf_w_slot_o  = r_w_slot;
  assign buf_w_addr_o  = r_w_addr;
  assign buf_w_data_o  = r_w_data;
  assign buf_w_mask_o  = r_w_mask;
  assign rx_ready_o    = r_rx_ready;
  assign rx_len_o      = r_rx_len;
  assign drop_count_o  = r_drop_cnt;

endmodule

// File: tb/tb_axis_rx_frame_writer.sv
// Directed bench: frame tasks push expected RAM writes into a queue, a
// negedge monitor pops and compares them; status outputs checked by hand values.
module tb_axis_rx_frame_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        buf_w_v_o, buf_w_slot_o;
  logic [7:0]  buf_w_addr_o, buf_w_mask_o;
  logic [63:0] buf_w_data_o;
  logic [1:0]  rx_ready_o;
  logic [23:0] rx_len_o;
  logic [1:0]  rx_clear_i = 2'b00;
  logic [15:0] drop_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        slot;
    logic [7:0]  addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [1:0]  rdy;
  } exp_t;
  exp_t q[$];

  axis_rx_frame_writer_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) axis ();

  axis_rx_frame_writer #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .BUF_ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis       (axis),
    .buf_w_v_o    (buf_w_v_o),
    .buf_w_slot_o (buf_w_slot_o),
    .buf_w_addr_o (buf_w_addr_o),
    .buf_w_data_o (buf_w_data_o),
    .buf_w_mask_o (buf_w_mask_o),
    .rx_ready_o   (rx_ready_o),
    .rx_len_o     (rx_len_o),
    .rx_clear_i   (rx_clear_i),
    .drop_count_o (drop_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && buf_w_v_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write slot %0d addr %0d got write want none", buf_w_slot_o, buf_w_addr_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_ctl{slot,addr,mask,rdy}", {45'd0, buf_w_slot_o, buf_w_addr_o, buf_w_mask_o, rx_ready_o},
            {45'd0, e.slot, e.addr, e.mask, e.rdy});
        chk("wr_data", buf_w_data_o, e.data);
      end
    end
  end

  function automatic logic [63:0] beat_data(input int id, input int i);
    return {32'(id), 32'(i)};
  endfunction

  task automatic frame(input int id, input int nbeats, input logic [7:0] lastkeep, input bit user,
                       input bit gap, input int nwr, input bit slot,
                       input logic [1:0] rdy_before, input logic [1:0] rdy_after);
    for (int i = 0; i < nwr; i++) begin
      exp_t e;
      e.slot = slot;
      e.addr = 8'(i);
      e.data = beat_data(id, i);
      e.mask = (i == nbeats - 1) ? lastkeep : 8'hFF;
      e.rdy  = (i == nwr - 1) ? rdy_after : rdy_before;
      q.push_back(e);
    end
    for (int i = 0; i < nbeats; i++) begin
      axis.tvalid = 1'b1;
      axis.tdata  = beat_data(id, i);
      axis.tkeep  = (i == nbeats - 1) ? lastkeep : 8'hFF;
      axis.tlast  = (i == nbeats - 1);
      axis.tuser  = user && (i == nbeats - 1);
      @(posedge clk); #1;
      if (gap) begin
        axis.tvalid = 1'b0;
        axis.tdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
      end
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    axis.tuser  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear(input logic [1:0] m);
    rx_clear_i = m;
    @(posedge clk); #1;
    rx_clear_i = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic status(input string nm, input logic [1:0] rdy, input logic [11:0] len1,
                        input logic [11:0] len0, input logic [15:0] drops);
    chk({nm, "_rdy"}, rx_ready_o, rdy);
    chk({nm, "_len"}, rx_len_o, {len1, len0});
    chk({nm, "_drop"}, drop_count_o, drops);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  initial begin
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tkeep  = '0;
    axis.tlast  = 1'b0;
    axis.tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", axis.tready, 1'b0);
    chk("rst_wv", buf_w_v_o, 1'b0);
    status("rst", 2'b00, 12'd0, 12'd0, 16'd0);
    rst_n = 1'b1;
    chk("rel_tready_pre", axis.tready, 1'b0);
    @(posedge clk); #1;
    chk("rel_tready", axis.tready, 1'b1);

    // 64B good frame into slot 0
    frame(1, 8, 8'hFF, 0, 0, 8, 1'b0, 2'b00, 2'b01);
    status("A", 2'b01, 12'd0, 12'd64, 16'd0);
    clear(2'b01);
    status("clr0", 2'b00, 12'd0, 12'd64, 16'd0);
    // 8B single-beat frame moves ping-pong to slot 1
    frame(2, 1, 8'hFF, 0, 0, 1, 1'b1, 2'b00, 2'b10);
    status("F", 2'b10, 12'd8, 12'd64, 16'd0);
    clear(2'b10);
    // 61B frame with tvalid gaps, then 100B frame
    frame(3, 8, 8'h1F, 0, 1, 8, 1'b0, 2'b00, 2'b01);
    status("B", 2'b01, 12'd8, 12'd61, 16'd0);
    frame(4, 13, 8'h0F, 0, 0, 13, 1'b1, 2'b01, 2'b11);
    status("C", 2'b11, 12'd100, 12'd61, 16'd0);
    // No room: dropped without writes
    frame(5, 3, 8'hFF, 0, 0, 0, 1'b0, 2'b11, 2'b11);
    status("D", 2'b11, 12'd100, 12'd61, 16'd1);
    clear(2'b01);
    frame(6, 2, 8'hFF, 0, 0, 2, 1'b0, 2'b10, 2'b11);
    status("E", 2'b11, 12'd100, 12'd16, 16'd1);
    clear(2'b10);
    // Bad frame: written but discarded; slot reused from addr 0
    frame(7, 3, 8'hFF, 1, 0, 3, 1'b1, 2'b01, 2'b01);
    status("G", 2'b01, 12'd100, 12'd16, 16'd2);
    frame(8, 1, 8'h07, 0, 0, 1, 1'b1, 2'b01, 2'b11);
    status("H", 2'b11, 12'd3, 12'd16, 16'd2);
    clear(2'b11);
    status("clr11", 2'b00, 12'd3, 12'd16, 16'd2);
    // Oversize: 256 writes, beat 257 discarded
    frame(9, 257, 8'hFF, 0, 0, 256, 1'b0, 2'b00, 2'b00);
    status("I", 2'b00, 12'd3, 12'd16, 16'd3);
    // Zero-length frame
    frame(10, 1, 8'h00, 0, 0, 1, 1'b0, 2'b00, 2'b00);
    status("J", 2'b00, 12'd3, 12'd16, 16'd4);

    // Reset mid-frame with a tvalid gap
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.slot = 1'b0; e.addr = 8'(i); e.data = beat_data(11, i); e.mask = 8'hFF; e.rdy = 2'b00;
      q.push_back(e);
    end
    axis.tvalid = 1'b1; axis.tdata = beat_data(11, 0); axis.tkeep = 8'hFF;
    @(posedge clk); #1;
    axis.tvalid = 1'b0;
    @(posedge clk); #1;
    axis.tvalid = 1'b1; axis.tdata = beat_data(11, 1);
    @(posedge clk); #1;
    axis.tdata = beat_data(11, 2);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    axis.tvalid = 1'b0;
    chk("mrst_tready", axis.tready, 1'b0);
    chk("mrst_wv", buf_w_v_o, 1'b0);
    chk("mrst_wdata", buf_w_data_o, 64'd0);
    status("mrst", 2'b00, 12'd0, 12'd0, 16'd0);
    chk("mrst_q_empty", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrel_tready", axis.tready, 1'b1);
    frame(12, 1, 8'hFF, 0, 0, 1, 1'b0, 2'b00, 2'b01);
    status("K", 2'b01, 12'd0, 12'd8, 16'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_q_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
